// File: rtl/sprite_lookup.sv
// rtl/sprite_lookup.sv - sprite register bank with sequential lowest-index coordinate match
module sprite_lookup #(
    parameter int          N_SPRITES   = 32,
    parameter int          IDX_W       = 5,
    parameter int          SPRITE_SIZE = 20,
    parameter logic [31:0] BG_CODE     = 32'h00000001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [31:0]      wr_data,
    input  logic             lookup_req,
    input  logic [17:0]      check_value,
    output logic             lookup_busy,
    output logic             lookup_valid,
    output logic [31:0]      data_reg,
    output logic [IDX_W-1:0] hit_index
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [31:0]      regs [N_SPRITES];
    logic [0:0]       state;
    logic [IDX_W-1:0] idx;
    logic [8:0]       px;
    logic [8:0]       py;

    logic [31:0] cur;
    logic [9:0]  ox_end;
    logic [9:0]  oy_end;
    logic        hit;
    logic        last;

    // Box ends are formed at 10 bits so a sprite near 511 never wraps to low coordinates.
    always_comb begin
        cur    = regs[idx];
        ox_end = {1'b0, cur[26:18]} + 10'(SPRITE_SIZE);
        oy_end = {1'b0, cur[17:9]} + 10'(SPRITE_SIZE);
        hit    = cur[31]
                 && (px >= cur[26:18]) && ({1'b0, px} < ox_end)
                 && (py >= cur[17:9])  && ({1'b0, py} < oy_end);
        last   = (idx == IDX_W'(N_SPRITES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= '0;
            px           <= '0;
            py           <= '0;
            lookup_busy  <= 1'b0;
            lookup_valid <= 1'b0;
            data_reg     <= BG_CODE;
            hit_index    <= '0;
        end else begin
            lookup_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (lookup_req) begin
                        px          <= check_value[17:9];
                        py          <= check_value[8:0];
                        idx         <= '0;
                        lookup_busy <= 1'b1;
                        state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        data_reg     <= cur;
                        hit_index    <= idx;
                        lookup_valid <= 1'b1;
                        lookup_busy  <= 1'b0;
                        state        <= S_IDLE;
                    end else if (last) begin
                        data_reg     <= BG_CODE;
                        hit_index    <= '0;
                        lookup_valid <= 1'b1;
                        lookup_busy  <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    lookup_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_lookup.sv
// tb/tb_sprite_lookup.sv - randomized and directed self-checking bench for sprite_lookup
module tb_sprite_lookup;

    localparam int          N    = 32;
    localparam int          SZ   = 20;
    localparam logic [31:0] BG   = 32'h00000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        lookup_req = 1'b0;
    logic [17:0] check_value = '0;
    logic        lookup_busy;
    logic        lookup_valid;
    logic [31:0] data_reg;
    logic [4:0]  hit_index;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [N];

    sprite_lookup #(
        .N_SPRITES(N), .IDX_W(5), .SPRITE_SIZE(SZ), .BG_CODE(BG)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lookup_req(lookup_req), .check_value(check_value), .lookup_busy(lookup_busy),
        .lookup_valid(lookup_valid), .data_reg(data_reg), .hit_index(hit_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rec(input bit en, input int ox, input int oy, input int base);
        return {en, 4'b0, 9'(ox), 9'(oy), 9'(base)};
    endfunction

    // Reference: first enabled record whose box contains the pixel, using unbounded integers.
    function automatic int ref_hit(input int px, input int py);
        for (int k = 0; k < N; k++) begin
            int ox = int'(model[k][26:18]);
            int oy = int'(model[k][17:9]);
            if (model[k][31] && px >= ox && px < ox + SZ && py >= oy && py < oy + SZ)
                return k;
        end
        return -1;
    endfunction

    task automatic write_rec(input int k, input logic [31:0] v);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'(k); wr_data = v;
        @(negedge clk);
        wr_en = 1'b0;
        model[k] = v;
    endtask

    task automatic do_lookup(input int px, input int py, input bit do_wr, input int wk,
                             input logic [31:0] wv, input int wcyc,
                             output logic [31:0] got_data, output int got_idx, output int lat);
        @(negedge clk);
        lookup_req = 1'b1;
        check_value = {9'(px), 9'(py)};
        @(negedge clk);
        lookup_req = 1'b0;
        check_value = ~check_value;
        lat = 0;
        while (!lookup_valid && lat < 200) begin
            if (do_wr && lat == wcyc) begin
                wr_en = 1'b1; wr_addr = 5'(wk); wr_data = wv;
            end
            @(negedge clk);
            wr_en = 1'b0;
            lat++;
        end
        if (do_wr) model[wk] = wv;
        if (!lookup_valid) check("lookup_timeout", 32'(lat), 32'd0);
        check("busy_with_valid", {31'b0, lookup_busy}, 32'd0);
        got_data = data_reg;
        got_idx  = int'(hit_index);
        @(negedge clk);
        check("valid_one_cycle", {31'b0, lookup_valid}, 32'd0);
    endtask

    task automatic lookup_vs_model(input string tag, input int px, input int py);
        logic [31:0] d;
        int hi, lat, k;
        k = ref_hit(px, py);
        do_lookup(px, py, 1'b0, 0, 32'd0, 0, d, hi, lat);
        check({tag, "_data"}, d, (k < 0) ? BG : model[k]);
        check({tag, "_idx"}, 32'(hi), (k < 0) ? 32'd0 : 32'(k));
        check({tag, "_lat"}, 32'(lat), (k < 0) ? 32'(N) : 32'(k + 1));
    endtask

    initial begin
        logic [31:0] d;
        int hi, lat, nv;

        for (int k = 0; k < N; k++) model[k] = '0;
        repeat (2) @(negedge clk);
        check("rst_data", data_reg, BG);
        check("rst_valid", {31'b0, lookup_valid}, 32'd0);
        check("rst_busy", {31'b0, lookup_busy}, 32'd0);
        check("rst_idx", {27'b0, hit_index}, 32'd0);
        reset = 1'b0;

        lookup_vs_model("empty", 100, 100);

        write_rec(3, rec(1, 40, 60, 9'h0A5));
        lookup_vs_model("r3_in", 59, 79);
        lookup_vs_model("r3_xout", 60, 79);
        lookup_vs_model("r3_yout", 40, 80);

        write_rec(2, rec(1, 45, 45, 9'h011));
        write_rec(7, rec(1, 40, 40, 9'h022));
        lookup_vs_model("prio2", 50, 50);
        write_rec(2, rec(0, 45, 45, 9'h011));
        lookup_vs_model("prio7", 50, 50);

        write_rec(0, rec(1, 500, 0, 9'h1FF));
        lookup_vs_model("edge_hit", 511, 5);
        lookup_vs_model("no_wrap", 4, 5);

        // Disabling record 10 while idx 5 is evaluated must turn the result into a miss.
        write_rec(10, rec(1, 290, 290, 9'h033));
        do_lookup(300, 300, 1'b1, 10, 32'd0, 5, d, hi, lat);
        check("mid_dis_data", d, BG);
        check("mid_dis_lat", 32'(lat), 32'(N));
        // Record 5 is written in the same cycle it is evaluated, so the old contents apply.
        write_rec(10, rec(1, 290, 290, 9'h033));
        do_lookup(300, 300, 1'b1, 5, rec(1, 295, 295, 9'h044), 5, d, hi, lat);
        check("mid_same_idx", 32'(hi), 32'd10);
        check("mid_same_data", d, rec(1, 290, 290, 9'h033));
        lookup_vs_model("after_mid", 300, 300);

        for (int t = 0; t < 40; t++) begin
            write_rec($urandom_range(N - 1),
                      rec($urandom_range(1), $urandom_range(120), $urandom_range(120),
                          $urandom_range(511)));
            lookup_vs_model("rand", $urandom_range(140), $urandom_range(140));
        end

        // Reset mid-scan.
        @(negedge clk);
        lookup_req = 1'b1; check_value = {9'd300, 9'd300};
        @(negedge clk);
        lookup_req = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", {31'b0, lookup_busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'b0, lookup_busy}, 32'd0);
        check("mid_rst_data", data_reg, BG);
        nv = 0;
        repeat (3) begin
            @(negedge clk);
            if (lookup_valid) nv++;
        end
        reset = 1'b0;
        for (int k = 0; k < N; k++) model[k] = '0;
        repeat (40) begin
            @(negedge clk);
            if (lookup_valid) nv++;
        end
        check("mid_rst_no_valid", 32'(nv), 32'd0);
        for (int t = 0; t < 4; t++)
            lookup_vs_model("post_rst", $urandom_range(511), $urandom_range(511));

        // Request held high through the scan restarts exactly once after the result.
        @(negedge clk);
        lookup_req = 1'b1; check_value = {9'd10, 9'd10};
        lat = 0;
        while (!lookup_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("held_lat", 32'(lat), 32'(N + 1));
        @(negedge clk);
        lookup_req = 1'b0;
        check("held_restart_busy", {31'b0, lookup_busy}, 32'd1);
        nv = 0;
        repeat (80) begin
            @(negedge clk);
            if (lookup_valid) nv++;
        end
        check("held_one_restart", 32'(nv), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
